hazard_control_unit: RTL

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: operand forwarding, load-use/RAW stalls, branch flushes,
// multi-cycle data-memory stall FSM and saturating performance counters.
`timescale 1ns/1ps
module hazard_control_unit #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned FWD_EN  = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic [REG_AW-1:0] idex_rs1,
  input  logic [REG_AW-1:0] idex_rs2,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_memread,
  input  logic              idex_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_regwrite,
  input  logic              exmem_memread,
  input  logic              exmem_memwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_regwrite,
  input  logic              branch_taken,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              mem_stall,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int unsigned WCW       = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam int unsigned WAIT_INIT = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01
  } state_e;

  state_e            state_q, state_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;
  logic              mem_stall_c;
  logic              mem_req;
  logic              load_use;
  logic              raw_hz;
  logic              hazard;

  // Priority select: EX/MEM result beats MEM/WB result; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              ex_wr,
    input logic [REG_AW-1:0] ex_rd,
    input logic              wb_wr,
    input logic [REG_AW-1:0] wb_rd
  );
    if (ex_wr && (ex_rd != '0) && (ex_rd == rs)) return 2'b10;
    if (wb_wr && (wb_rd != '0) && (wb_rd == rs)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic raw_match(
    input logic [REG_AW-1:0] rs,
    input logic              id_wr,
    input logic [REG_AW-1:0] id_rd,
    input logic              ex_wr,
    input logic [REG_AW-1:0] ex_rd
  );
    return (rs != '0) && ((id_wr && (id_rd == rs)) || (ex_wr && (ex_rd == rs)));
  endfunction

  assign mem_req  = exmem_memread | exmem_memwrite;
  assign load_use = idex_memread && (idex_rd != '0) &&
                    ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
  // Without forwarding every in-flight producer of a decode source must drain first.
  assign raw_hz   = (FWD_EN == 0) &&
                    (raw_match(ifid_rs1, idex_regwrite, idex_rd, exmem_regwrite, exmem_rd) ||
                     raw_match(ifid_rs2, idex_regwrite, idex_rd, exmem_regwrite, exmem_rd));
  assign hazard   = load_use | raw_hz;

  // Memory-wait FSM next state; the release cycle never retriggers.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_stall_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_req && (MEM_LAT > 1)) begin
          mem_stall_c = 1'b1;
          wait_d      = WCW'(WAIT_INIT);
          state_d     = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (wait_q != '0) begin
          mem_stall_c = 1'b1;
          wait_d      = wait_q - WCW'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Pipeline control: memory stall > branch flush > hazard stall.
  always_comb begin
    forward_a   = 2'b00;
    forward_b   = 2'b00;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mem_stall   = 1'b0;
    if (!reset) begin
      if (FWD_EN != 0) begin
        forward_a = fwd_sel(idex_rs1, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
        forward_b = fwd_sel(idex_rs2, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
      end
      mem_stall = mem_stall_c;
      if (mem_stall_c) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end else if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (hazard) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_write && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (ifid_flush && (flush_count_q != '1)) flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      wait_q         <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule
